// File: rtl/cart_rom_fetch_pkg.sv
// cart_rom_fetch_pkg: shared definitions for the cartridge slot ROM fetch path
//   S_IDLE..S_DONE : fetch FSM state encodings
//   OPEN_BUS       : byte returned when nothing drives the bus (unmapped or aborted fetch)
package cart_rom_fetch_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_WAIT = 2'd2;
  localparam state_t S_DONE = 2'd3;
  localparam logic [7:0] OPEN_BUS = 8'hFF;
endpackage

// File: rtl/cart_fetch_cache.sv
// cart_fetch_cache: one-entry ROM byte cache (valid bit, 25-bit tag, data byte)
//   clk, reset       : clock, asynchronous active-high reset (invalidates)
//   flush            : invalidate the entry; also masks a same-cycle hit
//   fill/fill_addr/fill_data : write the entry with a fetched byte
//   lookup_addr      : address being looked up
//   hit, data        : lookup result and cached byte
module cart_fetch_cache
  import cart_rom_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        fill,
  input  logic [24:0] fill_addr,
  input  logic [7:0]  fill_data,
  input  logic [24:0] lookup_addr,
  output logic        hit,
  output logic [7:0]  data
);
  logic        valid;
  logic [24:0] tag;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= OPEN_BUS;
    end else if (flush) valid <= 1'b0;
    else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      data  <= fill_data;
    end
  // a flush arriving with the lookup means the image just changed, so never hit
  assign hit = valid & ~flush & (tag == lookup_addr);
endmodule

// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: fetches one ROM byte from SDRAM per CPU read of the cartridge slot
//   TIMEOUT_CYCLES : WAIT cycles allowed for ram_ack before the fetch is aborted
//   clk, reset     : clock, asynchronous active-high reset
//   cs, cpu_mreq, cpu_rd : CPU slot select, memory request, read strobe
//   mem_addr, mem_unmaped : mapped ROM address and out-of-image flag
//   flush          : ROM image reloaded (only used by the optional cache)
//   ram_addr, ram_rd, ram_ack, ram_din : SDRAM read port
//   dout, cpu_wait, timeout : byte to CPU, CPU stall, sticky abort flag
//   Define CART_FETCH_CACHE_EN to add the one-entry cart_fetch_cache.
module cart_rom_fetch
  import cart_rom_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        cpu_mreq,
  input  logic        cpu_rd,
  input  logic [24:0] mem_addr,
  input  logic        mem_unmaped,
  input  logic        flush,
  output logic [24:0] ram_addr,
  output logic        ram_rd,
  input  logic        ram_ack,
  input  logic [7:0]  ram_din,
  output logic [7:0]  dout,
  output logic        cpu_wait,
  output logic        timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic          start;
  logic          hit;
  logic [7:0]    hit_data;
  assign start = cs & cpu_mreq & cpu_rd & (state == S_IDLE);
  assign cpu_wait = ~reset & ((start & ~mem_unmaped & ~hit) | (state == S_REQ) | (state == S_WAIT));
`ifdef CART_FETCH_CACHE_EN
  // only acks accepted in WAIT fill, so a stray ack never caches a bogus byte
  cart_fetch_cache u_cache (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .fill        ((state == S_WAIT) & ram_ack),
    .fill_addr   (ram_addr),
    .fill_data   (ram_din),
    .lookup_addr (mem_addr),
    .hit         (hit),
    .data        (hit_data)
  );
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign hit = 1'b0;
  assign hit_data = OPEN_BUS;
`endif
  // ram_rd is raised on entry to REQ, so it is high exactly while in REQ
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= S_IDLE;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      dout     <= OPEN_BUS;
      timeout  <= 1'b0;
      cnt      <= '0;
    end else begin
      ram_rd <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            if (mem_unmaped) begin
              dout  <= OPEN_BUS;
              state <= S_DONE;
            end else if (hit) begin
              dout  <= hit_data;
              state <= S_DONE;
            end else begin
              ram_addr <= mem_addr;
              ram_rd   <= 1'b1;
              state    <= S_REQ;
            end
          end
        S_REQ: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          if (ram_ack) begin
            dout  <= ram_din;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            dout    <= OPEN_BUS;
            timeout <= 1'b1;
            state   <= S_DONE;
          end else cnt <= cnt + 1'b1;
        default: state <= cpu_mreq ? S_DONE : S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_cart_rom_fetch.sv
// tb_cart_rom_fetch: scoreboard bench for cart_rom_fetch with a delayed-ack SDRAM model
module tb_cart_rom_fetch;
  import cart_rom_fetch_pkg::*;
  localparam int TO = 8;
  logic        clk = 1'b0;
  logic        reset, cs, cpu_mreq, cpu_rd, mem_unmaped, flush;
  logic        ram_rd, ram_ack, cpu_wait, timeout;
  logic [24:0] mem_addr, ram_addr, last_addr;
  logic [7:0]  ram_din, dout, ack_data;
  logic [7:0]  exp_q[$];
  int n_chk = 0, n_pass = 0, rd_cnt = 0, wait_cnt = 0, ack_dly = -1;
  int r0, w0, n;
  cart_rom_fetch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .cpu_mreq    (cpu_mreq),
    .cpu_rd      (cpu_rd),
    .mem_addr    (mem_addr),
    .mem_unmaped (mem_unmaped),
    .flush       (flush),
    .ram_addr    (ram_addr),
    .ram_rd      (ram_rd),
    .ram_ack     (ram_ack),
    .ram_din     (ram_din),
    .dout        (dout),
    .cpu_wait    (cpu_wait),
    .timeout     (timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ram_rd) rd_cnt++;
    if (cpu_wait) wait_cnt++;
  end
  // SDRAM model: ack ack_dly cycles after the ram_rd cycle; negative = never ack
  initial forever begin
    @(negedge clk);
    if (ram_rd) begin
      last_addr = ram_addr;
      if (ack_dly >= 0) begin
        repeat (ack_dly) @(posedge clk);
        #1 ram_ack = 1'b1;
        ram_din = ack_data;
        @(posedge clk);
        #1 ram_ack = 1'b0;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_read(input string tag, input logic [24:0] a, input logic um, input logic hit,
                         input int dly, input logic [7:0] d, input int hold);
    int rd_s, w_s, k;
    logic [7:0] e;
    rd_s = rd_cnt;
    w_s = wait_cnt;
    ack_dly = dly;
    ack_data = d;
    exp_q.push_back((um || dly < 0) ? OPEN_BUS : d);
    @(posedge clk);
    #1 cs = 1'b1;
    cpu_mreq = 1'b1;
    cpu_rd = 1'b1;
    mem_addr = a;
    mem_unmaped = um;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cpu_wait && k < 4 * TO + 64);
    chk({tag, "_done"}, 32'(k < 4 * TO + 64), 1);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, "_dout"}, dout, e);
    if (!um && !hit) chk({tag, "_addr"}, last_addr, a);
    repeat (hold) @(negedge clk);
    chk({tag, "_rd"}, rd_cnt - rd_s, (um || hit) ? 0 : 1);
    chk({tag, "_wait"}, wait_cnt - w_s, (um || hit) ? 0 : (dly < 0 ? 2 + TO : 2 + dly));
    @(posedge clk);
    #1 cs = 1'b0;
    cpu_mreq = 1'b0;
    cpu_rd = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    cs = 1'b1;
    cpu_mreq = 1'b1;
    cpu_rd = 1'b1;
    mem_addr = 25'h0_4123;
    mem_unmaped = 1'b0;
    flush = 1'b0;
    ram_ack = 1'b0;
    ram_din = 8'h00;
    ack_data = 8'h00;
    last_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, OPEN_BUS);
    chk("rst_rd", ram_rd, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_wait", cpu_wait, 0);
    chk("rst_state", dut.state, S_IDLE);
    cs = 1'b0;
    cpu_mreq = 1'b0;
    cpu_rd = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    do_read("miss", 25'h0_4123, 1'b0, 1'b0, 3, 8'h5A, 0);
    chk("timeout_clear", timeout, 0);
    do_read("unmap", 25'h1FF_0000, 1'b1, 1'b0, 3, 8'h11, 0);
    do_read("tmo", 25'h0_2000, 1'b0, 1'b0, -1, 8'h00, 0);
    chk("timeout_set", timeout, 1);
    do_read("after_tmo", 25'h0_0100, 1'b0, 1'b0, 2, 8'hC3, 0);
    chk("timeout_sticky", timeout, 1);
    do_read("hold", 25'h0_0200, 1'b0, 1'b0, 1, 8'h3C, 10);
    r0 = rd_cnt;
    w0 = wait_cnt;
    @(posedge clk);
    #1 cs = 1'b1;
    cpu_mreq = 1'b1;
    cpu_rd = 1'b0;
    mem_addr = 25'h0_0400;
    mem_unmaped = 1'b0;
    repeat (4) @(negedge clk);
    chk("write_rd", rd_cnt - r0, 0);
    chk("write_wait", wait_cnt - w0, 0);
    @(posedge clk);
    #1 cs = 1'b0;
    cpu_mreq = 1'b0;
    ack_dly = -1;
    @(posedge clk);
    #1 cs = 1'b1;
    cpu_mreq = 1'b1;
    cpu_rd = 1'b1;
    mem_addr = 25'h0_0300;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ram_rd && n < 10);
    chk("rstw_req", ram_rd, 1);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rstw_state", dut.state, S_IDLE);
    chk("rstw_dout", dout, OPEN_BUS);
    chk("rstw_wait", cpu_wait, 0);
    chk("rstw_rd", ram_rd, 0);
    chk("rstw_addr", ram_addr, 0);
    chk("rstw_timeout", timeout, 0);
    cs = 1'b0;
    cpu_mreq = 1'b0;
    cpu_rd = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    r0 = rd_cnt;
    @(posedge clk);
    @(posedge clk);
    #1 ram_ack = 1'b1;
    ram_din = 8'h77;
    @(posedge clk);
    #1 ram_ack = 1'b0;
    @(negedge clk);
    chk("late_dout", dout, OPEN_BUS);
    chk("late_state", dut.state, S_IDLE);
    chk("late_wait", cpu_wait, 0);
    chk("late_rd", rd_cnt - r0, 0);
    do_read("post_rst", 25'h0_0500, 1'b0, 1'b0, 4, 8'hA5, 0);
`ifdef CART_FETCH_CACHE_EN
    do_read("cache1", 25'h1_0000, 1'b0, 1'b0, 2, 8'h42, 0);
    do_read("cache2", 25'h1_0000, 1'b0, 1'b1, 2, 8'h42, 0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    do_read("cache3", 25'h1_0000, 1'b0, 1'b0, 2, 8'h43, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
